// File: rtl/pipeline_types.sv
// Shared types and default timing constants for the WS2812 receive pipeline.
// Holds the bit decoder -> shift register handoff struct and the default
// cycle counts (50 MHz i_clk) used by bit_decoder.
package pipeline_types;

   // Default cycle constants at 50 MHz
   localparam int unsigned THRESH_CYC_DEF   = 30;    // 0.6 us: high width decoded as 1
   localparam int unsigned RESET_CYC_DEF    = 2500;  // 50 us: low width marking frame reset
   localparam int unsigned MAX_HIGH_CYC_DEF = 100;   // 2 us: high width treated as line error
   localparam int unsigned MIN_HIGH_CYC_DEF = 5;     // glitch-reject width (optional filter)

   // Handoff from bit_decoder to shift_register
   typedef struct packed {
      logic valid_strobe;  // one-cycle pulse: a bit was decoded
      logic decode_bit;    // decoded value, meaningful only with valid_strobe
      logic treset;        // one-cycle pulse: frame reset (long low) seen
   } shift_reg_input_t;

   // Narrow an integer cycle parameter to the 16-bit counter width
   function automatic logic [15:0] to_cyc16(input int unsigned value);
      logic [31:0] wide;
      wide = value;
      return wide[15:0];
   endfunction

   // Increment a 16-bit counter, holding it once it reaches limit
   function automatic logic [15:0] sat_inc16(input logic [15:0] cnt,
                                             input logic [15:0] limit);
      logic [15:0] result;
      if (cnt < limit) begin
         result = cnt + 16'd1;
      end else begin
         result = cnt;
      end
      return result;
   endfunction

endpackage

// File: rtl/din_synchronizer.sv
// Two-flop synchronizer bringing the raw asynchronous WS2812 line into the
// i_clk domain. Both flops clear to 0 on reset.
module din_synchronizer (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_din,
   output logic din_s
);

   logic meta_r;

   // Two-stage resynchronisation of the serial line
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         meta_r <= 1'b0;
         din_s  <= 1'b0;
      end else begin
         meta_r <= i_din;
         din_s  <= meta_r;
      end
   end

endmodule

// File: rtl/bit_decoder.sv
// WS2812 bit decoder: measures synchronized high/low widths of the serial
// line and emits one strobe per bit (1 when high >= THRESH_CYC), a frame
// reset pulse after RESET_CYC low cycles, and an error pulse for highs that
// last MAX_HIGH_CYC cycles.
// Optional build macro: BIT_DECODER_GLITCH_FILTER_EN -- highs shorter than
// MIN_HIGH_CYC are dropped silently and the low period keeps counting.
module bit_decoder
   import pipeline_types::*;
#(
   parameter int unsigned THRESH_CYC   = THRESH_CYC_DEF,
   parameter int unsigned RESET_CYC    = RESET_CYC_DEF,
   parameter int unsigned MAX_HIGH_CYC = MAX_HIGH_CYC_DEF,
   parameter int unsigned MIN_HIGH_CYC = MIN_HIGH_CYC_DEF
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_din,
   output shift_reg_input_t o_shift_reg,
   output logic             o_bit_err
);

   typedef enum logic [1:0] {
      ST_LOW  = 2'd0,
      ST_HIGH = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   localparam logic [15:0] THRESH_W = to_cyc16(THRESH_CYC);
   localparam logic [15:0] RESET_W  = to_cyc16(RESET_CYC);
   localparam logic [15:0] MAX_W    = to_cyc16(MAX_HIGH_CYC);
   localparam logic [15:0] MIN_W    = to_cyc16(MIN_HIGH_CYC);

`ifdef BIT_DECODER_GLITCH_FILTER_EN
   localparam logic FILTER_EN = 1'b1;
`else
   localparam logic FILTER_EN = 1'b0;
`endif

   logic             din_s;
   logic             din_d_r;
   logic [1:0]       fill_cnt_r;
   logic             primed_s;
   logic             rise_s;
   logic             fall_s;
   logic             glitch_s;

   state_t           state_r;
   state_t           state_s;
   logic [15:0]      low_cnt_r;
   logic [15:0]      low_cnt_s;
   logic [15:0]      high_cnt_r;
   logic [15:0]      high_cnt_s;

   logic             strobe_s;
   logic             bit_s;
   logic             treset_s;
   logic             err_s;

   shift_reg_input_t shift_reg_r;
   logic             bit_err_r;

   din_synchronizer u_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_din     (i_din),
      .din_s     (din_s)
   );

   // Delayed copy of the synchronized line plus a fill counter: din_d only
   // holds a real line sample three edges after reset, so edges seen before
   // that are artefacts of the cleared pipeline (a line already high at
   // reset release must not look like a rise).
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         din_d_r    <= 1'b0;
         fill_cnt_r <= 2'd0;
      end else begin
         din_d_r <= din_s;
         if (fill_cnt_r != 2'd3) begin
            fill_cnt_r <= fill_cnt_r + 2'd1;
         end
      end
   end

   assign primed_s = (fill_cnt_r == 2'd3);
   assign rise_s   = din_s & ~din_d_r & primed_s;
   assign fall_s   = ~din_s & din_d_r;
   assign glitch_s = FILTER_EN & (high_cnt_r < MIN_W);

   // Next-state, counter and pulse decode for the LOW/HIGH/ERR machine
   always_comb begin
      state_s    = state_r;
      low_cnt_s  = low_cnt_r;
      high_cnt_s = high_cnt_r;
      strobe_s   = 1'b0;
      bit_s      = 1'b0;
      treset_s   = 1'b0;
      err_s      = 1'b0;

      case (state_r)
         ST_LOW: begin
            if (rise_s) begin
               // The rise cycle is the first high cycle; the low count is
               // kept so a filtered glitch can resume it.
               high_cnt_s = 16'd1;
               state_s    = ST_HIGH;
            end else begin
               low_cnt_s = sat_inc16(low_cnt_r, RESET_W);
               if (low_cnt_r == (RESET_W - 16'd1)) begin
                  treset_s = 1'b1;
               end else begin
                  treset_s = 1'b0;
               end
            end
         end

         ST_HIGH: begin
            // A fall wins over the error check in the same cycle
            if (fall_s) begin
               state_s = ST_LOW;
               if (glitch_s) begin
                  low_cnt_s = low_cnt_r;
               end else begin
                  low_cnt_s = 16'd1;
                  strobe_s  = 1'b1;
                  bit_s     = (high_cnt_r >= THRESH_W);
               end
            end else if (high_cnt_r >= MAX_W) begin
               state_s = ST_ERR;
               err_s   = 1'b1;
            end else begin
               high_cnt_s = high_cnt_r + 16'd1;
            end
         end

         ST_ERR: begin
            if (!din_s) begin
               state_s   = ST_LOW;
               low_cnt_s = 16'd1;
            end else begin
               state_s = ST_ERR;
            end
         end

         default: begin
            state_s    = ST_LOW;
            low_cnt_s  = 16'd0;
            high_cnt_s = 16'd0;
         end
      endcase
   end

   // State and width counters
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r    <= ST_LOW;
         low_cnt_r  <= 16'd0;
         high_cnt_r <= 16'd0;
      end else begin
         state_r    <= state_s;
         low_cnt_r  <= low_cnt_s;
         high_cnt_r <= high_cnt_s;
      end
   end

   // Registered single-cycle output pulses
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shift_reg_r.valid_strobe <= 1'b0;
         shift_reg_r.decode_bit   <= 1'b0;
         shift_reg_r.treset       <= 1'b0;
         bit_err_r                <= 1'b0;
      end else begin
         shift_reg_r.valid_strobe <= strobe_s;
         shift_reg_r.decode_bit   <= bit_s;
         shift_reg_r.treset       <= treset_s;
         bit_err_r                <= err_s;
      end
   end

   assign o_shift_reg = shift_reg_r;
   assign o_bit_err   = bit_err_r;

endmodule

// File: doc/bit_decoder.md
BIT_DECODER -- requirements
Module: bit_decoder

Interface
REQ-001 Parameter THRESH_CYC, default 30, SHALL set the minimum synchronized high width in i_clk cycles decoded as bit 1 (0.6 us at 50 MHz).
REQ-002 Parameter RESET_CYC, default 2500, SHALL set the low width in cycles that signals a frame reset (50 us at 50 MHz).
REQ-003 Parameter MAX_HIGH_CYC, default 100, SHALL set the high width in cycles treated as a line error (2 us).
REQ-004 Parameter MIN_HIGH_CYC, default 5, SHALL set the glitch-reject width; it is used only under BIT_DECODER_GLITCH_FILTER_EN.
REQ-005 i_clk  input  1  sole clock; all state on rising edge.
REQ-006 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_din  input  1  raw asynchronous WS2812 serial line.
REQ-008 o_shift_reg  output  pipeline_types::shift_reg_input_t  {valid_strobe, decode_bit, treset}, fed to shift_register.
REQ-009 o_bit_err  output  1  one-cycle pulse when a high pulse reaches MAX_HIGH_CYC.

Function
REQ-010 i_din SHALL pass through a 2-flop synchronizer; all decoding SHALL use the second-stage output (din_s) and its one-cycle-delayed copy (din_d).
REQ-011 The FSM SHALL have states LOW, HIGH and ERR; it SHALL enter LOW after reset.
REQ-012 LOW: the 16-bit low counter SHALL increment per cycle, saturating at RESET_CYC; a rise (din_s=1, din_d=0) SHALL clear the high counter to 1 and go to HIGH.
REQ-013 HIGH: the 16-bit high counter SHALL increment per cycle; a fall (din_s=0, din_d=1) SHALL go to LOW, clear the low counter to 1, and register valid_strobe=1 with decode_bit = (high count >= THRESH_CYC).
REQ-014 HIGH: if the high count reaches MAX_HIGH_CYC with no fall that cycle, the FSM SHALL go to ERR, pulse o_bit_err, and emit no strobe; a fall in the same cycle SHALL take priority over the error.
REQ-015 ERR: the FSM SHALL wait for din_s=0, then go to LOW with the low counter cleared to 1 and no strobe.
REQ-016 treset SHALL pulse for exactly one cycle when the low counter transitions to RESET_CYC, and once only per low period.
REQ-017 valid_strobe, treset and o_bit_err SHALL be registered single-cycle pulses, mutually exclusive.
REQ-018 valid_strobe SHALL assert on the 3rd rising edge after the first edge that samples i_din low; decode_bit SHALL be valid only while valid_strobe=1 and is 0 otherwise.
REQ-019 A line held high continuously out of reset SHALL produce no strobe (no rise seen) until it falls and rises again.

Reset
REQ-020 Asserting i_reset_n low at any time, including mid-pulse, SHALL immediately clear both synchronizer flops, din_d, the counters and all outputs to 0, and set the FSM to LOW; no partial bit is emitted after release.

Configuration
REQ-021 With BIT_DECODER_GLITCH_FILTER_EN defined, a fall with high count < MIN_HIGH_CYC SHALL return to LOW with no strobe, and the low counter SHALL continue from its pre-glitch value.
REQ-022 Without BIT_DECODER_GLITCH_FILTER_EN, every fall from HIGH SHALL produce a strobe, regardless of width.

Structure
REQ-023 Default cycle constants (THRESH, RESET, MAX_HIGH, MIN_HIGH) SHALL live in pipeline_types alongside shift_reg_input_t.
REQ-024 The state enum SHALL be local to the module.
REQ-025 The synchronizer SHALL be a separate sub-module, din_synchronizer (2-flop, async active-low reset).

Verification
REQ-026 Reset released, then 20 cycles high and 40 low -> one valid_strobe with decode_bit=0; treset=0.
REQ-027 40 cycles high, then 40 low -> one strobe with decode_bit=1 on the 3rd edge after i_din is first sampled low.
REQ-028 24 alternating 40/20-cycle-high bits, then 2600 cycles low -> 24 strobes with the matching pattern, then exactly one treset 2500 cycles after the last fall is detected.
REQ-029 120 cycles high -> o_bit_err pulses once at count 100, no strobe; the next 20-cycle-high bit decodes normally as 0.
REQ-030 3-cycle high glitch -> no strobe with the macro defined; one strobe with decode_bit=0 without it.
REQ-031 i_reset_n pulsed low during the 25th cycle of a 40-cycle high -> no strobe for that pulse; outputs are 0 during reset.
